// File: rtl/ae_buffer_sched.sv
// Acquisition-engine buffer sequencer: waits for the buffer fill threshold, then
// walks the channel list, positions the read pointer and streams each channel's samples.
module ae_buffer_sched #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned CH_WIDTH   = 6
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    start,
  input  logic                    refill_en,
  input  logic [ADDR_WIDTH-9:0]   cfg_threshold,
  input  logic [CH_WIDTH-1:0]     channel_num,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    ch_req,
  output logic [CH_WIDTH-1:0]     ch_index,
  input  logic [ADDR_WIDTH+2:0]   ch_start_addr,
  input  logic [ADDR_WIDTH+2:0]   ch_sample_cnt,
  output logic                    refill,
  output logic [ADDR_WIDTH-9:0]   threshold,
  input  logic                    reach_threshold,
  output logic                    address_set,
  output logic [ADDR_WIDTH+2:0]   read_address,
  output logic                    read_next,
  input  logic                    sample_ready,
  input  logic                    corr_ready,
  output logic                    corr_valid,
  output logic                    corr_last
);

  localparam int unsigned   SW       = ADDR_WIDTH + 3;
  localparam logic [SW:0]   CAPACITY = {1'b1, {SW{1'b0}}};
  localparam logic [SW-1:0] ONE      = SW'(1);

  typedef enum logic [2:0] {
    IDLE, FILL, CFG_RD, CFG_CHK, SET, PRIME, STREAM, DONE
  } state_t;

  state_t                  state_q;
  logic [CH_WIDTH-1:0]     chnum_q;
  logic [CH_WIDTH-1:0]     ch_index_q;
  logic [ADDR_WIDTH-9:0]   threshold_q;
  logic [SW-1:0]           read_address_q;
  logic [SW-1:0]           remaining_q;
  logic                    refill_q;
  logic                    ch_req_q;
  logic                    address_set_q;
  logic                    done_q;
  logic                    error_q;

  logic [SW:0]             end_addr_d;
  logic                    overrun_d;
  logic                    skip_d;
  logic                    xfer_d;
  logic                    last_xfer_d;
  logic                    advance_d;
  logic                    last_ch_d;

  assign end_addr_d  = {1'b0, ch_start_addr} + {1'b0, ch_sample_cnt};
  assign overrun_d   = end_addr_d > CAPACITY;
  assign skip_d      = (ch_sample_cnt == '0) || overrun_d;
  assign xfer_d      = (state_q == STREAM) && sample_ready && corr_ready && !abort;
  assign last_xfer_d = xfer_d && (remaining_q == ONE);
  assign advance_d   = ((state_q == CFG_CHK) && skip_d) || last_xfer_d;
  assign last_ch_d   = ({1'b0, ch_index_q} + 1'b1) == {1'b0, chnum_q};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= IDLE;
      chnum_q        <= '0;
      ch_index_q     <= '0;
      threshold_q    <= '0;
      read_address_q <= '0;
      remaining_q    <= '0;
      refill_q       <= 1'b0;
      ch_req_q       <= 1'b0;
      address_set_q  <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      refill_q      <= 1'b0;
      ch_req_q      <= 1'b0;
      address_set_q <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      if (abort) begin
        state_q    <= IDLE;
        ch_index_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: if (start) begin
            refill_q    <= refill_en;
            chnum_q     <= channel_num;
            threshold_q <= cfg_threshold;
            ch_index_q  <= '0;
            state_q     <= FILL;
          end
          // refill_q is high only in the first FILL cycle, when reach_threshold may still be stale
          FILL: if (!refill_q && reach_threshold) begin
            if (chnum_q == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= CFG_RD;
              ch_req_q <= 1'b1;
            end
          end
          CFG_RD: state_q <= CFG_CHK;
          CFG_CHK: begin
            read_address_q <= ch_start_addr;
            remaining_q    <= ch_sample_cnt;
            error_q        <= (ch_sample_cnt != '0) && overrun_d;
            if (!skip_d) begin
              state_q       <= SET;
              address_set_q <= 1'b1;
            end
          end
          SET:    state_q <= PRIME;
          PRIME:  if (sample_ready) state_q <= STREAM;
          STREAM: if (xfer_d) remaining_q <= remaining_q - ONE;
          DONE:   state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
        // Skips and the final transfer of a channel share one advance path
        if (advance_d) begin
          ch_index_q <= ch_index_q + 1'b1;
          if (last_ch_d) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q  <= CFG_RD;
            ch_req_q <= 1'b1;
          end
        end
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q & ~abort;
  assign error        = error_q & ~abort;
  assign ch_req       = ch_req_q & ~abort;
  assign address_set  = address_set_q & ~abort;
  assign ch_index     = ch_index_q;
  assign refill       = refill_q;
  assign threshold    = threshold_q;
  assign read_address = read_address_q;
  assign read_next    = xfer_d;
  assign corr_valid   = xfer_d;
  assign corr_last    = last_xfer_d;

endmodule

// File: tb/tb_ae_buffer_sched.sv
// Self-checking bench for ae_buffer_sched: config RAM and buffer models, table vectors,
// directed corner sequences and randomized passes against a pass-level reference model.
module tb_ae_buffer_sched;
  localparam int AW   = 15;
  localparam int CW   = 6;
  localparam int SW   = AW + 3;
  localparam int CAPI = 1 << SW;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          start = 1'b0, refill_en = 1'b0, abort = 1'b0;
  logic [AW-9:0] cfg_threshold = '0;
  logic [CW-1:0] channel_num = '0;
  logic          busy, done, error, ch_req, refill, address_set;
  logic          read_next, corr_valid, corr_last;
  logic [CW-1:0] ch_index;
  logic [AW-9:0] threshold;
  logic [SW-1:0] read_address;
  logic [SW-1:0] ch_start_addr = '0, ch_sample_cnt = '0;
  logic          reach_threshold = 1'b1, sample_ready = 1'b0, corr_ready = 1'b1;

  always #5 clk = ~clk;

  ae_buffer_sched #(.ADDR_WIDTH(AW), .CH_WIDTH(CW)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .refill_en(refill_en),
    .cfg_threshold(cfg_threshold), .channel_num(channel_num), .abort(abort),
    .busy(busy), .done(done), .error(error), .ch_req(ch_req), .ch_index(ch_index),
    .ch_start_addr(ch_start_addr), .ch_sample_cnt(ch_sample_cnt), .refill(refill),
    .threshold(threshold), .reach_threshold(reach_threshold), .address_set(address_set),
    .read_address(read_address), .read_next(read_next), .sample_ready(sample_ready),
    .corr_ready(corr_ready), .corr_valid(corr_valid), .corr_last(corr_last)
  );

  int checks = 0, failures = 0;
  int unsigned cfg_start[64];
  int unsigned cfg_cnt[64];
  int  fill_delay = 4, rt_cnt = 0, pr_cnt = 0, rdy_mode = 0;
  bit  drop_en = 1'b0;

  // Channel config RAM: one-cycle read latency
  always @(posedge clk) begin
    if (ch_req) begin
      ch_start_addr <= SW'(cfg_start[ch_index]);
      ch_sample_cnt <= SW'(cfg_cnt[ch_index]);
    end
  end

  // Buffer block: refill drops reach_threshold, address_set re-primes sample_ready (>=2 cycles)
  always @(posedge clk) begin
    if (refill) begin
      reach_threshold <= 1'b0;
      rt_cnt          <= fill_delay;
    end else if (rt_cnt > 1) rt_cnt <= rt_cnt - 1;
    else if (rt_cnt == 1) begin
      reach_threshold <= 1'b1;
      rt_cnt          <= 0;
    end
    if (address_set) begin
      sample_ready <= 1'b0;
      pr_cnt       <= $urandom_range(1, 3);
    end else if (pr_cnt > 1) pr_cnt <= pr_cnt - 1;
    else if (pr_cnt == 1) begin
      sample_ready <= 1'b1;
      pr_cnt       <= 0;
    end else if (drop_en) sample_ready <= ($urandom_range(0, 3) != 0);
    else sample_ready <= 1'b1;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: corr_ready = ~corr_ready;
        2: corr_ready = ($urandom_range(0, 1) == 1);
        default: corr_ready = 1'b1;
      endcase
    end
  end

  int mon_refill, mon_chreq, mon_aset, mon_reads, mon_done, mon_err, viol;
  int mon_aset_q[$], mon_last_q[$], mon_idx_q[$];
  int exp_aset_q[$], exp_last_q[$];
  bit pend = 1'b0, prev_aset = 1'b0;

  always @(negedge clk) begin
    if (refill) begin
      mon_refill++;
      pend = 1'b1;
    end else if (reach_threshold) pend = 1'b0;
    if (ch_req) begin
      mon_chreq++;
      mon_idx_q.push_back(int'(ch_index));
      if (pend) viol++;
    end
    if (address_set) begin
      mon_aset++;
      mon_aset_q.push_back(int'(read_address));
      if (prev_aset) viol++;
    end
    prev_aset = address_set;
    if (read_next) begin
      mon_reads++;
      if (corr_last) mon_last_q.push_back(mon_reads);
      if (!(sample_ready && corr_ready)) viol++;
    end
    if (read_next != corr_valid) viol++;
    if (corr_last && !corr_valid) viol++;
    if (done) mon_done++;
    if (error) mon_err++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    mon_refill = 0; mon_chreq = 0; mon_aset = 0; mon_reads = 0;
    mon_done = 0; mon_err = 0; viol = 0; pend = 1'b0; prev_aset = 1'b0;
    mon_aset_q.delete(); mon_last_q.delete(); mon_idx_q.delete();
  endtask

  task automatic pulse_start(input bit ren, input int thr, input int nch);
    refill_en     = ren;
    cfg_threshold = (AW-8)'(thr);
    channel_num   = CW'(nch);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 4000 && busy; i++) tick();
    chk({tag, ".timeout_busy"}, busy, 0);
    if (busy) begin
      abort = 1'b1; tick(); abort = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ctl"}, {busy, done, error, ch_req, refill, address_set, read_next, corr_valid, corr_last}, 0);
    chk({tag, ".ch_index"}, ch_index, 0);
    chk({tag, ".threshold"}, threshold, 0);
    chk({tag, ".read_address"}, read_address, 0);
  endtask

  task automatic check_pass(input string tag, input int e_refill, input int e_chreq,
                            input int e_err, input int e_reads);
    chk({tag, ".refills"}, mon_refill, e_refill);
    chk({tag, ".dones"}, mon_done, 1);
    chk({tag, ".errors"}, mon_err, e_err);
    chk({tag, ".reads"}, mon_reads, e_reads);
    chk({tag, ".ch_reqs"}, mon_chreq, e_chreq);
    chk({tag, ".address_sets"}, mon_aset_q.size(), exp_aset_q.size());
    for (int i = 0; i < mon_aset_q.size() && i < exp_aset_q.size(); i++)
      chk($sformatf("%s.aset_addr%0d", tag, i), mon_aset_q[i], exp_aset_q[i]);
    chk({tag, ".lasts"}, mon_last_q.size(), exp_last_q.size());
    for (int i = 0; i < mon_last_q.size() && i < exp_last_q.size(); i++)
      chk($sformatf("%s.last_pos%0d", tag, i), mon_last_q[i], exp_last_q[i]);
    for (int i = 0; i < mon_idx_q.size(); i++)
      chk($sformatf("%s.ch_index%0d", tag, i), mon_idx_q[i], i);
    chk({tag, ".protocol_violations"}, viol, 0);
  endtask

  task automatic run_pass(input string tag, input bit ren, input int thr, input int nch,
                          input int e_chreq, input int e_err, input int e_reads);
    clear_mon();
    pulse_start(ren, thr, nch);
    chk({tag, ".threshold"}, threshold, thr);
    wait_idle(tag);
    check_pass(tag, int'(ren), e_chreq, e_err, e_reads);
  endtask

  // Pass-level reference: each listed channel either streams cnt samples or is skipped
  task automatic ref_model(input int nch, output int e_chreq, output int e_err, output int e_reads);
    longint s, c;
    e_err = 0; e_reads = 0; e_chreq = nch;
    exp_aset_q.delete(); exp_last_q.delete();
    for (int i = 0; i < nch; i++) begin
      s = cfg_start[i];
      c = cfg_cnt[i];
      if (c == 0) continue;
      if (s + c > longint'(CAPI)) e_err++;
      else begin
        exp_aset_q.push_back(int'(s));
        e_reads += int'(c);
        exp_last_q.push_back(e_reads);
      end
    end
  endtask

  typedef struct {
    bit ren; int thr; int nch; int rdy;
    int st0; int cn0; int st1; int cn1; int st2; int cn2;
    int e_aset; int ea0; int ea1; int e_reads; int e_err;
    int e_nlast; int el0; int el1; int e_chreq;
  } vec_t;

  vec_t tv[5];

  initial begin
    int e_chreq, e_err, e_reads;
    tv[0] = '{1'b1, 2, 2, 0, 100, 16, 0, 8, 0, 0,       2, 100, 0, 24, 0, 2, 16, 24, 2};
    tv[1] = '{1'b0, 1, 1, 1, 500, 10, 0, 0, 0, 0,       1, 500, 0, 10, 0, 1, 10, 0, 1};
    tv[2] = '{1'b1, 3, 3, 0, 7, 0, CAPI-4, 5, 40, 3,    1, 40, 0, 3, 1, 1, 3, 0, 3};
    tv[3] = '{1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[4] = '{1'b0, 7, 1, 0, CAPI-5, 5, 0, 0, 0, 0,     1, CAPI-5, 0, 5, 0, 1, 5, 0, 1};

    clear_mon();
    repeat (3) tick();
    chk_all_zero("reset");
    rst_b = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      cfg_start[0] = tv[i].st0; cfg_cnt[0] = tv[i].cn0;
      cfg_start[1] = tv[i].st1; cfg_cnt[1] = tv[i].cn1;
      cfg_start[2] = tv[i].st2; cfg_cnt[2] = tv[i].cn2;
      rdy_mode = tv[i].rdy; drop_en = 1'b0; fill_delay = 4;
      exp_aset_q.delete(); exp_last_q.delete();
      if (tv[i].e_aset > 0) exp_aset_q.push_back(tv[i].ea0);
      if (tv[i].e_aset > 1) exp_aset_q.push_back(tv[i].ea1);
      if (tv[i].e_nlast > 0) exp_last_q.push_back(tv[i].el0);
      if (tv[i].e_nlast > 1) exp_last_q.push_back(tv[i].el1);
      run_pass($sformatf("vec%0d", i), tv[i].ren, tv[i].thr, tv[i].nch,
               tv[i].e_chreq, tv[i].e_err, tv[i].e_reads);
      tick();
    end
    rdy_mode = 0;

    // Empty pass without refill: done two cycles after start
    clear_mon();
    pulse_start(1'b0, 0, 0);
    chk("noref.refill_c1", refill, 0);
    chk("noref.done_c1", done, 0);
    tick();
    chk("noref.done_c2", done, 1);
    tick();
    chk("noref.busy_c3", busy, 0);

    // Refill pulse lands in the cycle after start and lasts one cycle
    clear_mon();
    pulse_start(1'b1, 3, 0);
    chk("refill.c1", refill, 1);
    tick();
    chk("refill.c2", refill, 0);
    wait_idle("refill");
    chk("refill.count", mon_refill, 1);

    // Abort three samples into the second channel
    cfg_start[0] = 1000; cfg_cnt[0] = 4;
    cfg_start[1] = 2000; cfg_cnt[1] = 16;
    clear_mon();
    pulse_start(1'b0, 1, 2);
    for (int i = 0; i < 500 && mon_reads < 7; i++) tick();
    chk("abort.reads_before", mon_reads, 7);
    abort = 1'b1;
    #1;
    chk("abort.strobes_low", {read_next, corr_valid, address_set, ch_req, done, error}, 0);
    tick();
    abort = 1'b0;
    chk("abort.busy_after", busy, 0);
    chk("abort.ch_index_after", ch_index, 0);
    repeat (10) tick();
    chk("abort.reads_after", mon_reads, 7);
    chk("abort.no_done", mon_done, 0);
    chk("abort.no_error", mon_err, 0);
    ref_model(2, e_chreq, e_err, e_reads);
    run_pass("after_abort", 1'b0, 1, 2, e_chreq, e_err, e_reads);
    tick();

    // Start while busy is ignored; original config stays latched
    cfg_start[0] = 300; cfg_cnt[0] = 6;
    cfg_start[1] = 600; cfg_cnt[1] = 5;
    fill_delay = 15;
    clear_mon();
    pulse_start(1'b1, 5, 2);
    repeat (3) tick();
    pulse_start(1'b1, 9, 1);
    chk("busy_start.threshold", threshold, 5);
    wait_idle("busy_start");
    ref_model(2, e_chreq, e_err, e_reads);
    check_pass("busy_start", 1, e_chreq, e_err, e_reads);
    tick();

    // Asynchronous reset in the middle of a stream
    fill_delay = 4;
    cfg_start[0] = 50; cfg_cnt[0] = 30;
    clear_mon();
    pulse_start(1'b0, 6, 1);
    for (int i = 0; i < 500 && mon_reads < 5; i++) tick();
    chk("midreset.reads_before", mon_reads, 5);
    rst_b = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick(); tick();
    rst_b = 1'b1;
    tick();

    // Randomized passes with random backpressure and buffer stalls
    rdy_mode = 2; drop_en = 1'b1;
    for (int p = 0; p < 30; p++) begin
      int nch, thr;
      bit ren;
      for (int c = 0; c < 8; c++) begin
        cfg_start[c] = ($urandom_range(0, 3) == 0) ? CAPI - $urandom_range(1, 40)
                                                   : $urandom_range(0, CAPI - 1);
        cfg_cnt[c]   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
      end
      nch = $urandom_range(0, 6);
      thr = $urandom_range(0, 127);
      ren = $urandom_range(0, 1) == 1;
      fill_delay = $urandom_range(1, 8);
      ref_model(nch, e_chreq, e_err, e_reads);
      run_pass($sformatf("rnd%0d", p), ren, thr, nch, e_chreq, e_err, e_reads);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ae_buffer_sched.md
# ae_buffer_sched

Sequencer for the acquisition-engine sample buffer read/write block. On a start command it optionally restarts the buffer fill and waits until the fill reaches a programmed threshold. It then walks a list of acquisition channels; for each one it fetches the start sample address and sample count from the channel config RAM, positions the buffer read pointer, and streams exactly that many samples to the correlator under a valid/ready handshake. It sits between the AE top-level control registers, the AE channel config RAM, the buffer read/write block and the correlator front end.

## Interface
- ADDR_WIDTH, 15, buffer DWORD address width; buffer capacity 2^(ADDR_WIDTH+3) samples
- CH_WIDTH, 6, channel index width
- clk  in  1  system clock
- rst_b  in  1  asynchronous reset, active low
- start  in  1  one-cycle pulse; ignored unless state is IDLE
- refill_en  in  1  sampled at start; 1 = restart buffer fill
- cfg_threshold  in  ADDR_WIDTH-8  fill threshold, in 256-DWORD units; sampled at start
- channel_num  in  CH_WIDTH  number of channels to process; sampled at start
- abort  in  1  synchronous abort, highest priority
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse when the pass completes
- error  out  1  one-cycle pulse when a channel is skipped for overrun
- ch_req  out  1  config RAM read strobe
- ch_index  out  CH_WIDTH  config RAM address; also the current channel
- ch_start_addr  in  ADDR_WIDTH+3  first sample address; valid 1 cycle after ch_req
- ch_sample_cnt  in  ADDR_WIDTH+3  samples to stream; valid 1 cycle after ch_req
- refill  out  1  to the buffer block
- threshold  out  ADDR_WIDTH-8  to the buffer block; registered
- reach_threshold  in  1  from the buffer block
- address_set  out  1  to the buffer block
- read_address  out  ADDR_WIDTH+3  to the buffer block; registered
- read_next  out  1  to the buffer block
- sample_ready  in  1  from the buffer block
- corr_ready  in  1  correlator can accept a sample
- corr_valid  out  1  buffer sample_out is valid for the correlator this cycle
- corr_last  out  1  marks the final sample of the current channel

## Operation
- All outputs reset to 0.
- The state machine has these states: IDLE, FILL, CFG_RD, CFG_CHK, SET, PRIME, STREAM, DONE.
- IDLE:
  - start latches refill_en, channel_num and cfg_threshold into threshold.
  - It sets ch_index=0.
  - If refill_en is set, refill pulses for 1 cycle. Go to FILL.
- FILL:
  - Wait for reach_threshold=1.
  - reach_threshold is not evaluated in the cycle refill is high, so a stale level cannot pass.
  - Then go to CFG_RD, or to DONE if channel_num=0.
- CFG_RD: ch_req=1 for 1 cycle. Go to CFG_CHK.
- CFG_CHK:
  - Latch ch_start_addr into read_address and ch_sample_cnt into the remaining counter.
  - Overrun check: the ADDR_WIDTH+4-bit sum start+cnt must not exceed 2^(ADDR_WIDTH+3).
  - cnt=0: skip the channel with no error.
  - Overrun: error pulses and the channel is skipped.
  - Otherwise go to SET.
- SET: address_set=1 for exactly 1 cycle. Go to PRIME.
- PRIME:
  - Wait for sample_ready=1. This takes at least 2 cycles after address_set.
  - address_set resets sample_ready in the buffer block, so sample_ready is not evaluated in the SET cycle.
- STREAM:
  - read_next = corr_valid = sample_ready & corr_ready. This path is combinational, with no register.
  - Each transfer decrements the remaining counter.
  - corr_last = corr_valid & (remaining==1).
  - On the last transfer, move to the next channel.
- Next channel / skip:
  - ch_index increments.
  - If ch_index+1 == channel_num, go to DONE; otherwise go to CFG_RD.
- DONE: done=1 for 1 cycle. Go to IDLE.
- abort in any state:
  - Next state is IDLE; ch_index is cleared.
  - read_next, address_set, ch_req and corr_valid are low in the abort cycle.
  - done and error are not pulsed.
- abort and start in the same cycle: abort wins.
- Asynchronous reset mid-pass returns to IDLE with all outputs 0.

## Timing
- From start to refill: refill is high the cycle after start.
- In FILL, reach_threshold is first checked 2 cycles after start.
- ch_req to the data latch: 1 cycle.
- ch_req to address_set: 2 cycles.
- In STREAM, one sample per cycle at full throughput when sample_ready and corr_ready are both held high.
- read_next never asserts outside STREAM.
- Total transfers per channel equals ch_sample_cnt exactly.
- After the final transfer of the last channel, done is high 1 cycle later.

## Test plan
- Normal pass:
  - Stimulus: start with refill_en=1, threshold=2, channel_num=2; channel 0 = start 100, cnt 16; channel 1 = start 0, cnt 8; corr_ready held at 1.
  - Required: 1 refill pulse; no reads before reach_threshold; 2 address_set pulses carrying 100 and 0; 24 read_next total; corr_last on transfers 16 and 24; then done.
- Backpressure: toggle corr_ready 1/0 each cycle with cnt=10 -> exactly 10 read_next, each only when corr_ready=1.
- Skips:
  - cnt=0 -> no address_set and no error.
  - start = 2^(ADDR_WIDTH+3)-4 with cnt=5 -> error pulse, no address_set, next channel processed.
- channel_num=0 with refill_en=0 -> done 2 cycles after start, with no ch_req.
- abort in STREAM after 3 of 16 samples -> read_next low from that cycle on; busy=0 next cycle; no done; a new start works normally.
- start while busy -> ignored; the config latched at the original start is unchanged.
